// File: rtl/seg_bus_decoder.sv
// Monitor for the 12-bit active-low multiplexed seven-segment bus: waits for a
// stable legal digit, decodes it to hex and keeps per-digit value/status with ageing.
module seg_bus_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] segs,
    input  logic        clr,
    output logic [15:0] val,
    output logic [3:0]  dp,
    output logic [3:0]  vld,
    output logic [3:0]  blank,
    output logic [3:0]  bad,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);
    localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT);
    // An all-ones bus is the electrically idle state (everything active-low).
    localparam logic [11:0]   BUS_IDLE = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic [11:0]   sync1_q, sync1_d;
    logic [11:0]   s_q, s_d;
    logic [11:0]   s_prev_q, s_prev_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   val_q, val_d;
    logic [3:0]    dp_q, dp_d;
    logic [3:0]    vld_q, vld_d;
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    bad_q, bad_d;
    logic          upd_q, upd_d;
    logic [1:0]    upd_idx_q, upd_idx_d;
    logic          err_q, err_d;
    logic [AW-1:0] age_q [4];
    logic [AW-1:0] age_d [4];
    logic [AW-1:0] age_sat [4];
    logic [3:0]    age_hit;

    logic [3:0] sel;
    logic       multi;
    logic       legal;
    logic       same;
    logic [1:0] sel_idx;
    logic [6:0] pat;
    logic       dec_hit;
    logic [3:0] dec_val;
    logic       capture;

    assign sel   = ~{s_q[11], s_q[10], s_q[9], s_q[7]};
    assign multi = (sel & (sel - 4'd1)) != 4'd0;
    assign legal = (sel != 4'd0) && !multi;
    assign same  = (s_q == s_prev_q);
    assign pat   = ~s_q[6:0];

    always_comb begin
        sel_idx = 2'd0;
        if (sel[3])      sel_idx = 2'd3;
        else if (sel[2]) sel_idx = 2'd2;
        else if (sel[1]) sel_idx = 2'd1;
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'h0;
        case (pat)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_age
            assign age_sat[gi] = (age_q[gi] == AGE_MAX) ? age_q[gi] : age_q[gi] + AW'(1);
            assign age_hit[gi] = (age_sat[gi] == AGE_MAX);
        end
    endgenerate

    always_comb begin
        sync1_d   = segs;
        s_d       = sync1_q;
        s_prev_d  = s_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        val_d     = val_q;
        dp_d      = dp_q;
        vld_d     = vld_q;
        blank_d   = blank_q;
        bad_d     = bad_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_d     = err_q | multi;

        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_sat[i];
            if (age_hit[i]) vld_d[i] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            TRACK: begin
                if (!legal) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                    capture = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!same) begin
                    state_d = legal ? TRACK : IDLE;
                    cnt_d   = legal ? CNT_ONE : '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Capture overrides the ageing result for its own digit.
        if (capture) begin
            upd_d          = 1'b1;
            upd_idx_d      = sel_idx;
            dp_d[sel_idx]  = ~s_q[8];
            age_d[sel_idx] = '0;
            if (pat == 7'h00) begin
                blank_d[sel_idx] = 1'b1;
                bad_d[sel_idx]   = 1'b0;
                vld_d[sel_idx]   = 1'b1;
            end else if (dec_hit) begin
                val_d[{sel_idx, 2'b00} +: 4] = dec_val;
                blank_d[sel_idx] = 1'b0;
                bad_d[sel_idx]   = 1'b0;
                vld_d[sel_idx]   = 1'b1;
            end else begin
                blank_d[sel_idx] = 1'b0;
                bad_d[sel_idx]   = 1'b1;
                vld_d[sel_idx]   = 1'b0;
            end
        end

        if (clr) begin
            state_d   = IDLE;
            cnt_d     = '0;
            val_d     = '0;
            dp_d      = '0;
            vld_d     = '0;
            blank_d   = '0;
            bad_d     = '0;
            upd_d     = 1'b0;
            upd_idx_d = '0;
            err_d     = 1'b0;
            for (int i = 0; i < 4; i++) age_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= BUS_IDLE;
            s_q       <= BUS_IDLE;
            s_prev_q  <= BUS_IDLE;
            state_q   <= IDLE;
            cnt_q     <= '0;
            val_q     <= '0;
            dp_q      <= '0;
            vld_q     <= '0;
            blank_q   <= '0;
            bad_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) age_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            s_q       <= s_d;
            s_prev_q  <= s_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            dp_q      <= dp_d;
            vld_q     <= vld_d;
            blank_q   <= blank_d;
            bad_q     <= bad_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
            for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
        end
    end

    assign val     = val_q;
    assign dp      = dp_q;
    assign vld     = vld_q;
    assign blank   = blank_q;
    assign bad     = bad_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg_bus_decoder.sv
// Directed plus randomized bench for seg_bus_decoder; a run-length reference model
// predicts every output on every cycle.
module tb_seg_bus_decoder;

    localparam int SC = 4;
    localparam int TO = 16;
    localparam logic [6:0] HEX_PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] segs;
    logic        clr;
    logic [15:0] val;
    logic [3:0]  dp, vld, blank, bad;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;
    logic [35:0] dut_vec;

    seg_bus_decoder #(.STABLE_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .segs(segs), .clr(clr),
        .val(val), .dp(dp), .vld(vld), .blank(blank), .bad(bad),
        .upd(upd), .upd_idx(upd_idx), .err(err)
    );

    always #5 clk = ~clk;
    assign dut_vec = {val, dp, vld, blank, bad, upd, upd_idx, err};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [7:0] idx_log;

    // Reference model: bus delay line, run length of identical legal samples, outputs.
    logic [11:0] m_d0, m_d1, m_prev;
    int          m_run;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_vld, m_blank, m_bad;
    logic        m_upd;
    logic [1:0]  m_idx;
    logic        m_err;
    int          m_age [4];

    function automatic logic [35:0] mvec();
        return {m_val, m_dp, m_vld, m_blank, m_bad, m_upd, m_idx, m_err};
    endfunction

    function automatic logic [11:0] mk(input int d, input logic [6:0] p, input logic dp_on);
        logic [11:0] v;
        v      = 12'hFFF;
        v[6:0] = ~p;
        v[8]   = ~dp_on;
        case (d)
            0: v[7] = 1'b0;
            1: v[9] = 1'b0;
            2: v[10] = 1'b0;
            default: v[11] = 1'b0;
        endcase
        return v;
    endfunction

    task automatic model_clear();
        m_run = 0; m_val = '0; m_dp = '0; m_vld = '0; m_blank = '0; m_bad = '0;
        m_upd = 1'b0; m_idx = '0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    task automatic model_edge();
        logic [11:0] s, sp;
        logic [3:0]  act;
        logic [6:0]  p;
        int n, d, hit;
        if (!rst_n) begin
            m_d0 = 12'hFFF; m_d1 = 12'hFFF; m_prev = 12'hFFF;
            model_clear();
            return;
        end
        s = m_d1; sp = m_prev;
        m_prev = m_d1; m_d1 = m_d0; m_d0 = segs;
        if (clr) begin
            model_clear();
            return;
        end
        act = ~{s[11], s[10], s[9], s[7]};
        n = $countones(act);
        if (n > 1) m_err = 1'b1;
        if (n == 1) m_run = (m_run > 0 && s == sp) ? ((m_run > SC) ? m_run : m_run + 1) : 1;
        else        m_run = 0;
        m_upd = (n == 1) && (m_run == SC);
        for (int i = 0; i < 4; i++) begin
            if (m_age[i] < TO) m_age[i]++;
            if (m_age[i] == TO) m_vld[i] = 1'b0;
        end
        if (m_upd) begin
            d = act[3] ? 3 : act[2] ? 2 : act[1] ? 1 : 0;
            p = ~s[6:0];
            hit = -1;
            for (int k = 0; k < 16; k++) if (HEX_PAT[k] == p) hit = k;
            m_idx = 2'(d); m_dp[d] = ~s[8]; m_age[d] = 0;
            if (p == 7'h00) begin
                m_blank[d] = 1'b1; m_bad[d] = 1'b0; m_vld[d] = 1'b1;
            end else if (hit >= 0) begin
                m_val[d*4 +: 4] = 4'(hit);
                m_blank[d] = 1'b0; m_bad[d] = 1'b0; m_vld[d] = 1'b1;
            end else begin
                m_blank[d] = 1'b0; m_bad[d] = 1'b1; m_vld[d] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk($sformatf("cycle_%0d", cyc), dut_vec, mvec());
    endtask

    task automatic run(input int n, output int first_upd, output int n_upd);
        first_upd = -1;
        n_upd = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (upd === 1'b1) begin
                n_upd++;
                if (first_upd < 0) first_upd = k;
                idx_log = {idx_log[5:0], upd_idx};
            end
        end
    endtask

    initial begin
        int f, c, drop, hold;
        logic [11:0] v;
        logic [6:0]  p;
        rst_n = 1'b0; clr = 1'b0; segs = 12'hFFF; idx_log = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_state", dut_vec, 36'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Digit 0 shows "0", dp off: capture lands six cycles after the bus changes.
        segs = mk(0, 7'h3F, 1'b0);
        run(8, f, c);
        chk("t1_upd_cycle", 36'(f), 36'd6);
        chk("t1_upd_count", 36'(c), 36'd1);
        chk("t1_status", {20'd0, val[3:0], vld, dp, upd_idx, 2'b00}, {20'd0, 4'h0, 4'b0001, 4'b0000, 2'd0, 2'b00});

        idx_log = '0;
        segs = mk(0, 7'h06, 1'b0); run(8, f, c); drop = c;
        segs = mk(1, 7'h5B, 1'b0); run(8, f, c); drop += c;
        segs = mk(2, 7'h77, 1'b1); run(8, f, c); drop += c;
        segs = mk(3, 7'h71, 1'b0); run(8, f, c); drop += c;
        chk("t2_val", 36'(val), 36'hFA21);
        chk("t2_dp", 36'(dp), 36'b0100);
        chk("t2_upd_count", 36'(drop), 36'd4);
        chk("t2_idx_order", 36'(idx_log), 36'h1B);
        chk("t2_vld3", 36'(vld[3]), 36'd1);

        // Digit 1 "5" withdrawn before it is stable, then "7" must capture alone.
        segs = mk(1, 7'h6D, 1'b0); run(3, f, c);
        chk("t3_no_early", 36'(c), 36'd0);
        segs = mk(1, 7'h07, 1'b0); run(8, f, c);
        chk("t3_upd_cycle", 36'(f), 36'd6);
        chk("t3_upd_count", 36'(c), 36'd1);
        chk("t3_val1", 36'(val[7:4]), 36'h7);

        v = mk(0, 7'h3F, 1'b0); v[9] = 1'b0;
        segs = v; run(5, f, c);
        chk("t4_err_set", 36'(err), 36'd1);
        chk("t4_no_upd", 36'(c), 36'd0);
        segs = 12'hFFF; run(4, f, c);
        chk("t4_err_sticky", 36'(err), 36'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4_clr_all", dut_vec, 36'd0);

        segs = mk(3, 7'h49, 1'b0); run(7, f, c);
        chk("t5_bad", {33'd0, bad[3], vld[3], 1'b0}, {33'd0, 1'b1, 1'b0, 1'b0});
        chk("t5_val3_kept", 36'(val[15:12]), 36'h0);
        segs = mk(3, 7'h00, 1'b0); run(7, f, c);
        chk("t5_blank", {33'd0, blank[3], vld[3], bad[3]}, {33'd0, 3'b110});

        segs = mk(0, 7'h7F, 1'b0); run(6, f, c);
        chk("t6_capture", 36'(f), 36'd6);
        segs = 12'hFFF;
        drop = -1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (vld[0] === 1'b0) begin
                drop = j;
                break;
            end
        end
        chk("t6_age_drop", 36'(drop), 36'd16);

        segs = mk(2, 7'h4F, 1'b0); run(3, f, c);
        rst_n = 1'b0; tick();
        chk("t6_mid_reset", dut_vec, 36'd0);
        rst_n = 1'b1; run(8, f, c);
        chk("t6_restart_cycle", 36'(f), 36'd6);
        chk("t6_restart_count", 36'(c), 36'd1);

        // Random bursts: legal digits, blanks, junk, conflicts, idle, glitches, clears.
        for (int b = 0; b < 120; b++) begin
            case ($urandom_range(0, 5))
                0: p = 7'h00;
                1: p = 7'($urandom_range(0, 127));
                default: p = HEX_PAT[$urandom_range(0, 15)];
            endcase
            v = mk($urandom_range(0, 3), p, 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 9))
                0: v = 12'hFFF;
                1: begin v[9] = 1'b0; v[10] = 1'b0; end
                default: ;
            endcase
            segs = v;
            clr = ($urandom_range(0, 30) == 0);
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) begin
                tick();
                clr = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
